controlador_partida: RTL and testbench
======================================

Name: controlador_partida

Overview:
- Game sequencer for the battleship board: owns the DESLIGADO/PREPARACAO/ATAQUE flow the top level currently derives combinationally from ch7/ch6.
- Gates the map selector and the attack manager, issues one attack request per confirmed shot and waits for its hit/miss result.
- Tracks lives and hits, detects victory/defeat, and drives the status LEDs, matrix enable and display state code.
- Sits between decodificadorDeStatus/level_to_pulse and seletor_mapa/gerenciador_de_ataque, clocked by the divided clock.

Parameters:
- VIDAS, 3, lives at start of attack phase (1..7).
- CELULAS_NAVIO, 6, occupied map cells; reaching this hit count is victory (1..15).
- TIMEOUT, 8, cycles to wait for resultado_valido before aborting the shot (>=2).

Ports:
- clock_in  input  1  game clock (divided clock at top level).
- reset  input  1  synchronous, active-high reset.
- modo  input  2  {ch7,ch6}: 00 off, 01 preparation, 10 attack, 11 treated as off.
- confirmar  input  1  one-cycle confirm pulse (debounced btn0).
- coord_valida  input  1  current row/column switches are inside the 5x7 board.
- resultado_valido  input  1  attack datapath result strobe, one cycle.
- resultado_acerto  input  1  qualifies resultado_valido: 1 hit, 0 miss.
- resultado_repetido  input  1  qualifies resultado_valido: cell already attacked.
- enable_prep  output  1  enables the map selector.
- enable_ataque  output  1  enables the attack manager.
- gravar_mapa  output  1  one-cycle map-latch strobe.
- pedido_ataque  output  1  one-cycle attack request.
- ligar_matriz  output  1  LED matrix enable.
- vida  output  3  remaining lives.
- acertos  output  4  hits so far.
- estado  output  3  state code for the display.
- led_r, led_g, led_b  output  1 each  status LEDs, active high.

Behaviour:
- reset: state DESLIGADO, vida=VIDAS, acertos=0, mapa_ok=0, timeout counter 0, all strobes 0, all enables 0, LEDs off. All outputs are registered.
- States and codes: DESLIGADO 0, PREPARACAO 1, PRONTO 2, ESPERA 3, AGUARDA 4, VITORIA 5, DERROTA 6.
- modo 00/11, any state: next cycle DESLIGADO. Clears vida, acertos and mapa_ok to their reset values. Cancels any pending shot with no strobe.
- DESLIGADO + modo 01 -> PREPARACAO.
- DESLIGADO + modo 10 -> PREPARACAO. Attack is never entered without a latched map.
- PREPARACAO: enable_prep=1.
  - confirmar -> gravar_mapa=1 for exactly one cycle, mapa_ok=1, next PRONTO.
- PRONTO: enable_prep=1.
  - confirmar re-latches the map: gravar_mapa pulses, state stays PRONTO.
  - modo 10 -> ESPERA, loading vida=VIDAS and acertos=0.
- ESPERA: enable_ataque=1.
  - confirmar with coord_valida=1 -> pedido_ataque=1 for one cycle, next AGUARDA, timeout counter cleared.
  - confirmar with coord_valida=0 is ignored.
  - modo 01 -> PREPARACAO with mapa_ok=0, so the map must be re-chosen.
- AGUARDA: enable_ataque=1. Further confirmar pulses are ignored; exactly one request is outstanding.
  - resultado_valido with resultado_repetido=1 -> ESPERA, no counter change.
  - resultado_valido with acerto=1 -> acertos+1. If the new value equals CELULAS_NAVIO, next VITORIA; else ESPERA.
  - resultado_valido with acerto=0 -> vida-1. If the new value is 0, next DERROTA; else ESPERA.
  - repetido has priority over acerto.
  - Counter reaches TIMEOUT-1 with no result -> ESPERA, no counter change.
  - A result arriving on the timeout cycle is accepted.
- VITORIA/DERROTA: terminal until modo changes.
  - modo 00 -> DESLIGADO.
  - modo 01 -> PREPARACAO with mapa_ok=0.
  - confirmar is ignored.
- Saturation: vida never underflows below 0; acertos never exceeds CELULAS_NAVIO.
- Outputs:
  - ligar_matriz=1 in PREPARACAO, PRONTO, ESPERA and AGUARDA.
  - LEDs: PRONTO blue; ESPERA green; AGUARDA blue+green; VITORIA green+blue+red; DERROTA red; otherwise off.
  - estado equals the current state code.
- Latency: strobes appear the cycle after the confirmar/result input is sampled.

Optional Feature:
- Macro: LIMITE_TIROS_EN.
- With it:
  - Adds output tiros[5:0] (shots issued, reset/clear 0, saturating at 63) and parameter MAX_TIROS (default 20).
  - tiros increments on every pedido_ataque.
  - A resolved shot that leaves tiros==MAX_TIROS without victory goes to DERROTA.
  - Victory takes precedence on the same shot.
- Without it: no tiros port and no shot limit.

Test Plan:
- reset, modo=01, confirmar -> gravar_mapa high exactly 1 cycle, estado 1→2, blue LED on.
- modo=10 directly from reset -> estado=1 (PREPARACAO), enable_ataque never asserted.
- PRONTO, modo=10, 3 shots each answered with miss (VIDAS=3) -> vida 3→2→1→0, estado=6, led_r=1, ligar_matriz=0.
- 6 shots with hits, one repeated result interleaved -> acertos ends at 6, repeated shot leaves counters unchanged, estado=5.
- confirmar while in AGUARDA, then no result for 8 cycles -> one pedido_ataque only, return to ESPERA, vida unchanged.
- modo=00 mid-AGUARDA -> next cycle estado=0, vida=3, acertos=0; a late resultado_valido is ignored.

Source files
------------

// File: rtl/controlador_partida_if.sv
// Bundles the controlador_partida game-sequencer signals.
//   master : the sequencer (receives mode/confirm/result, drives strobes, enables and status)
//   slave  : the surrounding board logic (decoder, map selector, attack manager, display)
// Optional: LIMITE_TIROS_EN adds the tiros shot counter.
interface controlador_partida_if;
  logic [1:0] modo;
  logic       confirmar;
  logic       coord_valida;
  logic       resultado_valido;
  logic       resultado_acerto;
  logic       resultado_repetido;
  logic       enable_prep;
  logic       enable_ataque;
  logic       gravar_mapa;
  logic       pedido_ataque;
  logic       ligar_matriz;
  logic [2:0] vida;
  logic [3:0] acertos;
  logic [2:0] estado;
  logic       led_r;
  logic       led_g;
  logic       led_b;
`ifdef LIMITE_TIROS_EN
  logic [5:0] tiros;
`endif

  modport master (
    input  modo, confirmar, coord_valida, resultado_valido, resultado_acerto, resultado_repetido,
    output enable_prep, enable_ataque, gravar_mapa, pedido_ataque, ligar_matriz,
    output vida, acertos, estado, led_r, led_g, led_b
`ifdef LIMITE_TIROS_EN
    , output tiros
`endif
  );

  modport slave (
    output modo, confirmar, coord_valida, resultado_valido, resultado_acerto, resultado_repetido,
    input  enable_prep, enable_ataque, gravar_mapa, pedido_ataque, ligar_matriz,
    input  vida, acertos, estado, led_r, led_g, led_b
`ifdef LIMITE_TIROS_EN
    , input tiros
`endif
  );
endinterface

// File: rtl/controlador_partida.sv
// controlador_partida: battleship game sequencer.
// Runs off -> map preparation -> ready -> attack (request / wait for result) -> victory/defeat,
// tracking lives and hits and driving enables, strobes, LEDs and the display state code.
// Ports:
//   clock_in : game clock (divided clock)
//   reset    : synchronous, active-high
//   bus      : controlador_partida_if.master (mode, confirm, result inputs; all outputs registered)
// Optional: define LIMITE_TIROS_EN to add the tiros counter and the MAX_TIROS shot limit.
module controlador_partida #(
  parameter int unsigned VIDAS         = 3,
  parameter int unsigned CELULAS_NAVIO = 6,
  parameter int unsigned TIMEOUT       = 8
`ifdef LIMITE_TIROS_EN
  , parameter int unsigned MAX_TIROS   = 20
`endif
) (
  input logic                    clock_in,
  input logic                    reset,
  controlador_partida_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StDesligado  = 3'd0,
    StPreparacao = 3'd1,
    StPronto     = 3'd2,
    StEspera     = 3'd3,
    StAguarda    = 3'd4,
    StVitoria    = 3'd5,
    StDerrota    = 3'd6
  } estado_e;

  estado_e           state_q, state_d;
  logic [2:0]        vida_q, vida_d;
  logic [3:0]        acertos_q, acertos_d;
  logic              mapa_ok_q, mapa_ok_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gravar_q, gravar_d;
  logic              pedido_q, pedido_d;
  logic              en_prep_q, en_prep_d;
  logic              en_ataque_q, en_ataque_d;
  logic              matriz_q, matriz_d;
  logic              led_r_q, led_r_d;
  logic              led_g_q, led_g_d;
  logic              led_b_q, led_b_d;
  logic              modo_off;
  logic              vitoria;
  logic              derrota;
  logic              limite;
  logic [3:0]        acertos_inc;
  logic [2:0]        vida_dec;
`ifdef LIMITE_TIROS_EN
  logic [5:0]        tiros_q, tiros_d;
`endif

  assign modo_off    = (bus.modo == 2'b00) || (bus.modo == 2'b11);
  assign acertos_inc = (acertos_q < 4'(CELULAS_NAVIO)) ? acertos_q + 4'd1 : acertos_q;
  assign vida_dec    = (vida_q != 3'd0) ? vida_q - 3'd1 : 3'd0;

  always_comb begin
    state_d   = state_q;
    vida_d    = vida_q;
    acertos_d = acertos_q;
    mapa_ok_d = mapa_ok_q;
    cnt_d     = cnt_q;
    gravar_d  = 1'b0;
    pedido_d  = 1'b0;
    vitoria   = 1'b0;
    derrota   = 1'b0;
    limite    = 1'b0;
`ifdef LIMITE_TIROS_EN
    tiros_d   = tiros_q;
    // Counted at request time, so tiros_q already includes the shot being resolved.
    limite    = (tiros_q == 6'(MAX_TIROS));
`endif

    if (modo_off) begin
      // Off wins from any state and drops any outstanding shot silently.
      state_d   = StDesligado;
      vida_d    = 3'(VIDAS);
      acertos_d = 4'd0;
      mapa_ok_d = 1'b0;
      cnt_d     = '0;
`ifdef LIMITE_TIROS_EN
      tiros_d   = 6'd0;
`endif
    end else begin
      unique case (state_q)
        // Both 01 and 10 land in preparation: a map must be latched before attacking.
        StDesligado: state_d = StPreparacao;
        StPreparacao: begin
          if (bus.confirmar) begin
            gravar_d  = 1'b1;
            mapa_ok_d = 1'b1;
            state_d   = StPronto;
          end
        end
        StPronto: begin
          if (bus.modo == 2'b10 && mapa_ok_q) begin
            state_d   = StEspera;
            vida_d    = 3'(VIDAS);
            acertos_d = 4'd0;
`ifdef LIMITE_TIROS_EN
            tiros_d   = 6'd0;
`endif
          end else if (bus.confirmar) begin
            gravar_d = 1'b1;
          end
        end
        StEspera: begin
          if (bus.modo == 2'b01) begin
            state_d   = StPreparacao;
            mapa_ok_d = 1'b0;
          end else if (bus.confirmar && bus.coord_valida) begin
            pedido_d = 1'b1;
            cnt_d    = '0;
            state_d  = StAguarda;
`ifdef LIMITE_TIROS_EN
            tiros_d  = (tiros_q != 6'd63) ? tiros_q + 6'd1 : tiros_q;
`endif
          end
        end
        StAguarda: begin
          if (bus.modo == 2'b01) begin
            state_d   = StPreparacao;
            mapa_ok_d = 1'b0;
          end else if (bus.resultado_valido) begin
            // Result is checked before the timeout so one arriving on the last cycle counts.
            if (!bus.resultado_repetido) begin
              if (bus.resultado_acerto) begin
                acertos_d = acertos_inc;
                vitoria   = (acertos_inc == 4'(CELULAS_NAVIO));
              end else begin
                vida_d  = vida_dec;
                derrota = (vida_dec == 3'd0);
              end
            end
            if (vitoria)                state_d = StVitoria;
            else if (derrota || limite) state_d = StDerrota;
            else                        state_d = StEspera;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d = StEspera;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StVitoria, StDerrota: begin
          if (bus.modo == 2'b01) begin
            state_d   = StPreparacao;
            mapa_ok_d = 1'b0;
          end
        end
        default: state_d = StDesligado;
      endcase
    end

    en_prep_d   = (state_d == StPreparacao) || (state_d == StPronto);
    en_ataque_d = (state_d == StEspera) || (state_d == StAguarda);
    matriz_d    = en_prep_d || en_ataque_d;
    led_r_d     = (state_d == StVitoria) || (state_d == StDerrota);
    led_g_d     = (state_d == StEspera) || (state_d == StAguarda) || (state_d == StVitoria);
    led_b_d     = (state_d == StPronto) || (state_d == StAguarda) || (state_d == StVitoria);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q     <= StDesligado;
      vida_q      <= 3'(VIDAS);
      acertos_q   <= 4'd0;
      mapa_ok_q   <= 1'b0;
      cnt_q       <= '0;
      gravar_q    <= 1'b0;
      pedido_q    <= 1'b0;
      en_prep_q   <= 1'b0;
      en_ataque_q <= 1'b0;
      matriz_q    <= 1'b0;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
      led_b_q     <= 1'b0;
`ifdef LIMITE_TIROS_EN
      tiros_q     <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      vida_q      <= vida_d;
      acertos_q   <= acertos_d;
      mapa_ok_q   <= mapa_ok_d;
      cnt_q       <= cnt_d;
      gravar_q    <= gravar_d;
      pedido_q    <= pedido_d;
      en_prep_q   <= en_prep_d;
      en_ataque_q <= en_ataque_d;
      matriz_q    <= matriz_d;
      led_r_q     <= led_r_d;
      led_g_q     <= led_g_d;
      led_b_q     <= led_b_d;
`ifdef LIMITE_TIROS_EN
      tiros_q     <= tiros_d;
`endif
    end
  end

  assign bus.enable_prep   = en_prep_q;
  assign bus.enable_ataque = en_ataque_q;
  assign bus.gravar_mapa   = gravar_q;
  assign bus.pedido_ataque = pedido_q;
  assign bus.ligar_matriz  = matriz_q;
  assign bus.vida          = vida_q;
  assign bus.acertos       = acertos_q;
  assign bus.estado        = state_q;
  assign bus.led_r         = led_r_q;
  assign bus.led_g         = led_g_q;
  assign bus.led_b         = led_b_q;
`ifdef LIMITE_TIROS_EN
  assign bus.tiros         = tiros_q;
`endif

endmodule

// File: tb/tb_controlador_partida.sv
module tb_controlador_partida;

  localparam int VidasIni = 3;
  localparam int Celulas  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controlador_partida_if bus ();

  controlador_partida dut (
    .clock_in (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    int vida;
    int acertos;
    int estado;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vida_m;
  int   acertos_m;
  logic ultimo_pedido;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.modo = 2'b01;
    bus.confirmar = 1'b0;
    bus.coord_valida = 1'b0;
    bus.resultado_valido = 1'b0;
    bus.resultado_acerto = 1'b0;
    bus.resultado_repetido = 1'b0;
    cyc(2);
    bus.modo = 2'b00;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_confirm();
    bus.confirmar = 1'b1;
    cyc(1);
    bus.confirmar = 1'b0;
  endtask

  task automatic go_ataque();
    do_reset();
    bus.modo = 2'b01;
    cyc(1);
    pulse_confirm();
    bus.modo = 2'b10;
    cyc(1);
    vida_m = VidasIni;
    acertos_m = 0;
  endtask

  // Issues one shot and answers it; the expected outcome goes to the scoreboard.
  task automatic shot(input logic acerto, input logic rep);
    exp_t e;
    bus.coord_valida = 1'b1;
    pulse_confirm();
    ultimo_pedido = bus.pedido_ataque;
    if (!rep) begin
      if (acerto) begin
        if (acertos_m < Celulas) acertos_m++;
      end else if (vida_m > 0) begin
        vida_m--;
      end
    end
    e.vida = vida_m;
    e.acertos = acertos_m;
    e.estado = (acertos_m == Celulas) ? 5 : (vida_m == 0) ? 6 : 3;
    sb_q.push_back(e);
    bus.resultado_valido = 1'b1;
    bus.resultado_acerto = acerto;
    bus.resultado_repetido = rep;
    cyc(1);
    bus.resultado_valido = 1'b0;
    bus.resultado_acerto = 1'b0;
    bus.resultado_repetido = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.modo = 2'b01;
    bus.confirmar = 1'b1;
    bus.coord_valida = 1'b0;
    bus.resultado_valido = 1'b0;
    bus.resultado_acerto = 1'b0;
    bus.resultado_repetido = 1'b0;
    cyc(2);
    bus.confirmar = 1'b0;
    checks++;
    if (bus.estado !== 3'd0) begin
      failures++; $display("FAIL reset_estado: got %0d expected 0", bus.estado);
    end
    checks++;
    if (bus.vida !== 3'd3 || bus.acertos !== 4'd0) begin
      failures++; $display("FAIL reset_contadores: got vida=%0d acertos=%0d expected 3/0",
                           bus.vida, bus.acertos);
    end
    checks++;
    if ({bus.enable_prep, bus.enable_ataque, bus.gravar_mapa, bus.pedido_ataque,
         bus.ligar_matriz, bus.led_r, bus.led_g, bus.led_b} !== 8'b0) begin
      failures++; $display("FAIL reset_saidas: got %b expected 00000000",
                           {bus.enable_prep, bus.enable_ataque, bus.gravar_mapa,
                            bus.pedido_ataque, bus.ligar_matriz, bus.led_r, bus.led_g, bus.led_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_preparacao();
    do_reset();
    bus.modo = 2'b01;
    cyc(1);
    checks++;
    if (bus.estado !== 3'd1 || bus.enable_prep !== 1'b1 || bus.ligar_matriz !== 1'b1) begin
      failures++; $display("FAIL prep_entrada: got estado=%0d prep=%b matriz=%b expected 1/1/1",
                           bus.estado, bus.enable_prep, bus.ligar_matriz);
    end
    pulse_confirm();
    checks++;
    if (bus.gravar_mapa !== 1'b1 || bus.estado !== 3'd2 || bus.led_b !== 1'b1) begin
      failures++; $display("FAIL prep_gravar: got gravar=%b estado=%0d led_b=%b expected 1/2/1",
                           bus.gravar_mapa, bus.estado, bus.led_b);
    end
    cyc(1);
    checks++;
    if (bus.gravar_mapa !== 1'b0) begin
      failures++; $display("FAIL prep_gravar_um_ciclo: got %b expected 0", bus.gravar_mapa);
    end
    pulse_confirm();
    checks++;
    if (bus.gravar_mapa !== 1'b1 || bus.estado !== 3'd2) begin
      failures++; $display("FAIL pronto_regravar: got gravar=%b estado=%0d expected 1/2",
                           bus.gravar_mapa, bus.estado);
    end
  endtask

  task automatic test_ataque_sem_mapa();
    int viu_ataque = 0;
    int fora_prep = 0;
    do_reset();
    bus.modo = 2'b10;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.enable_ataque) viu_ataque++;
      if (i > 0 && bus.estado !== 3'd1) fora_prep++;
    end
    checks++;
    if (viu_ataque != 0 || fora_prep != 0) begin
      failures++; $display("FAIL sem_mapa: got ataque=%0d fora_prep=%0d expected 0/0",
                           viu_ataque, fora_prep);
    end
  endtask

  task automatic test_derrota();
    exp_t e;
    go_ataque();
    checks++;
    if (bus.estado !== 3'd3 || bus.vida !== 3'd3 || bus.led_g !== 1'b1) begin
      failures++; $display("FAIL ataque_entrada: got estado=%0d vida=%0d led_g=%b expected 3/3/1",
                           bus.estado, bus.vida, bus.led_g);
    end
    for (int i = 0; i < 3; i++) begin
      shot(1'b0, 1'b0);
      checks++;
      if (ultimo_pedido !== 1'b1) begin
        failures++; $display("FAIL derrota_pedido%0d: got %b expected 1", i, ultimo_pedido);
      end
      e = sb_q.pop_front();
      checks++;
      if (bus.vida !== 3'(e.vida) || bus.estado !== 3'(e.estado)) begin
        failures++; $display("FAIL derrota_tiro%0d: got vida=%0d estado=%0d expected %0d/%0d",
                             i, bus.vida, bus.estado, e.vida, e.estado);
      end
    end
    checks++;
    if (bus.led_r !== 1'b1 || bus.ligar_matriz !== 1'b0 || bus.enable_ataque !== 1'b0) begin
      failures++; $display("FAIL derrota_saidas: got r=%b matriz=%b ataque=%b expected 1/0/0",
                           bus.led_r, bus.ligar_matriz, bus.enable_ataque);
    end
  endtask

  task automatic test_vitoria();
    exp_t e;
    logic [1:0] padrao [7];
    // {repetido, acerto}; the repeated result also claims a hit to exercise priority
    padrao = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
    go_ataque();
    for (int i = 0; i < 7; i++) begin
      shot(padrao[i][0], padrao[i][1]);
      e = sb_q.pop_front();
      checks++;
      if (bus.acertos !== 4'(e.acertos) || bus.vida !== 3'(e.vida) ||
          bus.estado !== 3'(e.estado)) begin
        failures++; $display("FAIL vitoria_tiro%0d: got a=%0d v=%0d e=%0d expected %0d/%0d/%0d",
                             i, bus.acertos, bus.vida, bus.estado, e.acertos, e.vida, e.estado);
      end
    end
    checks++;
    if ({bus.led_r, bus.led_g, bus.led_b} !== 3'b111) begin
      failures++; $display("FAIL vitoria_leds: got %b expected 111",
                           {bus.led_r, bus.led_g, bus.led_b});
    end
    pulse_confirm();
    checks++;
    if (bus.estado !== 3'd5 || bus.pedido_ataque !== 1'b0) begin
      failures++; $display("FAIL vitoria_terminal: got estado=%0d pedido=%b expected 5/0",
                           bus.estado, bus.pedido_ataque);
    end
    bus.modo = 2'b01;
    cyc(1);
    bus.modo = 2'b10;
    cyc(3);
    checks++;
    if (bus.estado !== 3'd1 || bus.enable_ataque !== 1'b0) begin
      failures++; $display("FAIL vitoria_volta_prep: got estado=%0d ataque=%b expected 1/0",
                           bus.estado, bus.enable_ataque);
    end
  endtask

  task automatic test_timeout();
    int n_aguarda = 1;
    int n_pedido;
    bit voltou = 0;
    go_ataque();
    bus.coord_valida = 1'b0;
    pulse_confirm();
    checks++;
    if (bus.estado !== 3'd3 || bus.pedido_ataque !== 1'b0) begin
      failures++; $display("FAIL coord_invalida: got estado=%0d pedido=%b expected 3/0",
                           bus.estado, bus.pedido_ataque);
    end
    bus.coord_valida = 1'b1;
    pulse_confirm();
    n_pedido = int'(bus.pedido_ataque);
    for (int i = 0; i < 20; i++) begin
      bus.confirmar = (i == 1);
      cyc(1);
      if (bus.estado === 3'd4) n_aguarda++;
      if (bus.pedido_ataque === 1'b1) n_pedido++;
      if (bus.estado === 3'd3) begin
        voltou = 1;
        break;
      end
    end
    bus.confirmar = 1'b0;
    checks++;
    if (!voltou || n_aguarda != 8) begin
      failures++; $display("FAIL timeout_duracao: got voltou=%0d ciclos=%0d expected 1/8",
                           voltou, n_aguarda);
    end
    checks++;
    if (n_pedido != 1 || bus.vida !== 3'd3) begin
      failures++; $display("FAIL timeout_pedido: got pedidos=%0d vida=%0d expected 1/3",
                           n_pedido, bus.vida);
    end
    // A result on the last waiting cycle is still accepted.
    pulse_confirm();
    cyc(7);
    bus.resultado_valido = 1'b1;
    cyc(1);
    bus.resultado_valido = 1'b0;
    checks++;
    if (bus.vida !== 3'd2 || bus.estado !== 3'd3) begin
      failures++; $display("FAIL resultado_no_limite: got vida=%0d estado=%0d expected 2/3",
                           bus.vida, bus.estado);
    end
  endtask

  task automatic test_desliga();
    exp_t e;
    go_ataque();
    shot(1'b1, 1'b0);
    e = sb_q.pop_front();
    shot(1'b0, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if (bus.vida !== 3'(e.vida) || bus.acertos !== 4'(e.acertos)) begin
      failures++; $display("FAIL desliga_pre: got vida=%0d acertos=%0d expected %0d/%0d",
                           bus.vida, bus.acertos, e.vida, e.acertos);
    end
    pulse_confirm();
    bus.modo = 2'b00;
    cyc(1);
    checks++;
    if (bus.estado !== 3'd0 || bus.vida !== 3'd3 || bus.acertos !== 4'd0) begin
      failures++; $display("FAIL desliga_limpa: got e=%0d v=%0d a=%0d expected 0/3/0",
                           bus.estado, bus.vida, bus.acertos);
    end
    bus.resultado_valido = 1'b1;
    cyc(1);
    bus.resultado_valido = 1'b0;
    cyc(1);
    checks++;
    if (bus.estado !== 3'd0 || bus.vida !== 3'd3 || bus.ligar_matriz !== 1'b0) begin
      failures++; $display("FAIL desliga_tardio: got e=%0d v=%0d matriz=%b expected 0/3/0",
                           bus.estado, bus.vida, bus.ligar_matriz);
    end
  endtask

  initial begin
    test_reset();
    test_preparacao();
    test_ataque_sem_mapa();
    test_derrota();
    test_vitoria();
    test_timeout();
    test_desliga();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_vazio: got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
